// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns the game state, both scores and the shared play enable.
// PONG_AUTO_RESTART_EN: game-over times out to IDLE instead of waiting for a start edge.
module pong_match_ctrl #(
    parameter int SCORE_LIMIT = 9,
    parameter int PAUSE_TICKS = 25000000,
    parameter int OVER_TICKS  = 75000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_miss_left,
    input  logic       i_miss_right,
    output logic       o_game_active,
    output logic [3:0] o_score_left,
    output logic [3:0] o_score_right,
    output logic       o_serve_right,
    output logic       o_game_over,
    output logic       o_winner
);

    localparam int MAXT = (PAUSE_TICKS > OVER_TICKS) ? PAUSE_TICKS : OVER_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [3:0]    LIM      = 4'(SCORE_LIMIT);
    localparam logic [CW-1:0] PAUSE_LD = CW'(PAUSE_TICKS - 1);
`ifdef PONG_AUTO_RESTART_EN
    localparam logic [CW-1:0] OVER_LD  = CW'(OVER_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_RALLY,
        S_OVER
    } state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [3:0]    r_sl, r_sr, w_sl_nx, w_sr_nx;
    logic          r_serve, w_serve_nx;
    logic          r_winner, w_winner_nx;
    logic          r_active, r_over, r_start_d;
    logic          w_start_edge, w_cnt_zero;
    logic [3:0]    w_sl_inc, w_sr_inc;

    assign w_start_edge = i_start & ~r_start_d;
    assign w_cnt_zero   = (r_cnt == '0);
    // Saturating increments so a score can never pass the limit
    assign w_sl_inc     = (r_sl >= LIM) ? LIM : r_sl + 4'd1;
    assign w_sr_inc     = (r_sr >= LIM) ? LIM : r_sr + 4'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        w_sl_nx     = r_sl;
        w_sr_nx     = r_sr;
        w_serve_nx  = r_serve;
        w_winner_nx = r_winner;
        unique case (r_state)
            S_IDLE: begin
                w_sl_nx = '0;
                w_sr_nx = '0;
                if (w_start_edge) begin
                    w_state_nx = S_SERVE;
                    w_cnt_nx   = PAUSE_LD;
                end
            end
            S_SERVE: begin
                if (w_cnt_zero)
                    w_state_nx = S_RALLY;
            end
            S_RALLY: begin
                if (i_miss_left && i_miss_right) begin
                    w_state_nx = S_SERVE;
                    w_cnt_nx   = PAUSE_LD;
                end else if (i_miss_left) begin
                    w_sr_nx    = w_sr_inc;
                    w_serve_nx = 1'b1;
                    w_state_nx = S_SERVE;
                    w_cnt_nx   = PAUSE_LD;
                    if (w_sr_inc == LIM) begin
                        w_state_nx  = S_OVER;
                        w_winner_nx = 1'b1;
`ifdef PONG_AUTO_RESTART_EN
                        w_cnt_nx    = OVER_LD;
`endif
                    end
                end else if (i_miss_right) begin
                    w_sl_nx    = w_sl_inc;
                    w_serve_nx = 1'b0;
                    w_state_nx = S_SERVE;
                    w_cnt_nx   = PAUSE_LD;
                    if (w_sl_inc == LIM) begin
                        w_state_nx  = S_OVER;
                        w_winner_nx = 1'b0;
`ifdef PONG_AUTO_RESTART_EN
                        w_cnt_nx    = OVER_LD;
`endif
                    end
                end
            end
            S_OVER: begin
`ifdef PONG_AUTO_RESTART_EN
                if (w_cnt_zero) begin
                    w_state_nx  = S_IDLE;
                    w_sl_nx     = '0;
                    w_sr_nx     = '0;
                    w_winner_nx = 1'b0;
                end
`else
                if (w_start_edge) begin
                    w_state_nx  = S_SERVE;
                    w_cnt_nx    = PAUSE_LD;
                    w_sl_nx     = '0;
                    w_sr_nx     = '0;
                    w_serve_nx  = 1'b0;
                    w_winner_nx = 1'b0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sl      <= '0;
            r_sr      <= '0;
            r_serve   <= 1'b0;
            r_winner  <= 1'b0;
            r_active  <= 1'b0;
            r_over    <= 1'b0;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_sl      <= w_sl_nx;
            r_sr      <= w_sr_nx;
            r_serve   <= w_serve_nx;
            r_winner  <= w_winner_nx;
            r_active  <= (w_state_nx == S_RALLY);
            r_over    <= (w_state_nx == S_OVER);
            r_start_d <= i_start;
        end
    end

    assign o_game_active = r_active;
    assign o_score_left  = r_sl;
    assign o_score_right = r_sr;
    assign o_serve_right = r_serve;
    assign o_game_over   = r_over;
    assign o_winner      = r_winner;

endmodule
